// File: rtl/spi_slave_apb.sv
// Shared definitions for the APB memory responder: FSM state encoding and
// the fill value returned when the memory side stops answering.
package spi_slave_apb;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait counter for the memory handshake; expired is high during the
// LIMIT-th consecutive enabled cycle since the last clear.
module apb_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/apb_mem_responder.sv
// APB slave that forwards a word-addressed window onto a req/gnt/rvalid
// memory port, with a bounded wait on the memory side.
module apb_mem_responder
  import spi_slave_apb::*;
#(
  parameter int unsigned                APB_ADDR_WIDTH = 32,
  parameter int unsigned                APB_DATA_WIDTH = 32,
  parameter int unsigned                MEM_ADDR_WIDTH = 16,
  parameter logic [APB_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter int unsigned                TIMEOUT_CYCLES = 255
) (
  input  logic                      pclk_i,
  input  logic                      preset_ni,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic                      pwrite_i,
  input  logic [APB_DATA_WIDTH-1:0] pwdata_i,
  output logic [APB_DATA_WIDTH-1:0] prdata_o,
  output logic                      pready_o,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [APB_DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                      mem_rvalid_i,
  input  logic [APB_DATA_WIDTH-1:0] mem_rdata_i,
  output logic                      timeout_o
);

  localparam logic [APB_DATA_WIDTH-1:0] TIMEOUT_DATA = APB_DATA_WIDTH'(DEAD_BEEF);

  state_t                    state_reg;
  state_t                    state_next;
  logic [APB_ADDR_WIDTH-1:0] offset;
  logic                      in_window;
  logic                      expired;
  logic                      timeout_hit;

  assign offset    = paddr_i - BASE_ADDR;
  assign in_window = (paddr_i >= BASE_ADDR) && ((offset >> MEM_ADDR_WIDTH) == '0);

  // Purely state-decoded so an asynchronous reset drops the request at once.
  assign mem_req_o = (state_reg == ST_REQ);
  assign pready_o  = (state_reg == ST_DONE) && psel_i && penable_i;

  assign timeout_hit = expired &&
                       (((state_reg == ST_REQ)  && !mem_gnt_i) ||
                        ((state_reg == ST_RESP) && !mem_rvalid_i));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (psel_i) state_next = in_window ? ST_REQ : ST_DONE;
      ST_REQ: begin
        if (mem_gnt_i)    state_next = mem_we_o ? ST_DONE : ST_RESP;
        else if (expired) state_next = ST_DONE;
      end
      ST_RESP: if (mem_rvalid_i || expired) state_next = ST_DONE;
      ST_DONE: if (pready_o || !psel_i) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Clearing on every transition restarts the count on entry to REQ and RESP.
  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (pclk_i),
    .rst_n   (preset_ni),
    .clear   (state_next != state_reg),
    .enable  ((state_reg == ST_REQ) || (state_reg == ST_RESP)),
    .expired (expired)
  );

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_reg   <= ST_IDLE;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      prdata_o    <= '0;
      timeout_o   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == ST_IDLE) && psel_i) begin
        mem_we_o    <= pwrite_i;
        mem_addr_o  <= MEM_ADDR_WIDTH'(offset);
        mem_wdata_o <= pwdata_i;
        if (!in_window) prdata_o <= '0;
      end
      if ((state_reg == ST_RESP) && mem_rvalid_i) prdata_o <= mem_rdata_i;
      if (timeout_hit) begin
        prdata_o  <= TIMEOUT_DATA;
        timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_responder.sv
// Randomized self-checking bench: an APB master, a behavioural memory slave
// and a transaction-level reference model of the expected APB results.
module tb_apb_mem_responder;

  logic        clk = 1'b0;
  logic        preset_ni;
  logic        psel, psel_b, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  logic [31:0] prdata, mem_wdata;
  logic        pready, mem_req, mem_we, timeout;
  logic [7:0]  mem_addr;

  logic [31:0] b_prdata, b_mem_wdata;
  logic        b_pready, b_mem_req, b_mem_we, b_timeout;
  logic [7:0]  b_mem_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] slave_mem [0:255];
  logic [31:0] ref_mem   [0:255];
  logic [31:0] exp_prdata;

  always #5 clk = ~clk;

  apb_mem_responder #(
    .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .MEM_ADDR_WIDTH(8),
    .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(8)
  ) dut (
    .pclk_i(clk), .preset_ni(preset_ni), .psel_i(psel), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata),
    .pready_o(pready), .mem_req_o(mem_req), .mem_gnt_i(gnt), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rvalid_i(rvalid),
    .mem_rdata_i(rdata), .timeout_o(timeout)
  );

  apb_mem_responder #(
    .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .MEM_ADDR_WIDTH(8),
    .BASE_ADDR(32'h100), .TIMEOUT_CYCLES(8)
  ) dut_b (
    .pclk_i(clk), .preset_ni(preset_ni), .psel_i(psel_b), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(b_prdata),
    .pready_o(b_pready), .mem_req_o(b_mem_req), .mem_gnt_i(gnt), .mem_we_o(b_mem_we),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_rvalid_i(rvalid),
    .mem_rdata_i(rdata), .timeout_o(b_timeout)
  );

  // One APB transfer on dut, starting with the setup phase in the cycle after
  // the call; the memory slave grants after gdly REQ cycles and answers after
  // rdly RESP cycles. Returns the pready cycle index (-1 if it never came).
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input int gdly, input int rdly, output int lat,
                      output logic [31:0] rd, output int ngr, output logic [7:0] g_addr,
                      output logic g_we, output logic [31:0] g_wd, output logic saw_req);
    int kreq, kresp;
    logic in_resp;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
    gnt = 1'b0; rvalid = 1'b0;
    lat = -1; rd = '0; ngr = 0; g_addr = '0; g_we = 1'b0; g_wd = '0; saw_req = 1'b0;
    kreq = 0; kresp = 0; in_resp = 1'b0;
    for (int c = 1; c <= 64 && lat < 0; c++) begin
      @(posedge clk); #1;
      penable = 1'b1; gnt = 1'b0; rvalid = 1'b0;
      if (mem_req) begin
        saw_req = 1'b1;
        if (kreq == gdly) gnt = 1'b1;
        kreq++;
      end else if (in_resp) begin
        if (kresp == rdly) begin
          rvalid = 1'b1;
          rdata  = slave_mem[g_addr];
        end
        kresp++;
      end
      @(negedge clk);
      if (gnt) begin
        ngr++;
        g_addr = mem_addr; g_we = mem_we; g_wd = mem_wdata;
        if (mem_we) slave_mem[mem_addr] = mem_wdata;
        else in_resp = 1'b1;
      end
      if (pready) begin
        lat = c;
        rd  = prdata;
      end
    end
    gnt = 1'b0; rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psel = 1'b0; psel_b = 1'b0; penable = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    end
  endtask

  task automatic b_step(input logic sel, input logic en, input logic g, input logic rv,
                        input logic [31:0] rdv);
    @(posedge clk); #1;
    psel_b = sel; penable = en; gnt = g; rvalid = rv; rdata = rdv;
    @(negedge clk);
  endtask

  task automatic test_reset;
    preset_ni = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, pready, timeout} !== '0 || prdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h rdy=%b to=%b prdata=%h required all zero",
               mem_req, mem_we, mem_addr, mem_wdata, pready, timeout, prdata);
    end
    preset_ni = 1'b1;
    idle(2);
    @(negedge clk);
    checks++;
    if (pready !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got pready=%b mem_req=%b required 0 0", pready, mem_req);
    end
    exp_prdata = 32'h0;
  endtask

  task automatic test_write;
    int lat, ngr; logic [31:0] rd, gwd; logic [7:0] ga; logic gwe, sr;
    xfer(32'h10, 1'b1, 32'hCAFE0001, 0, 0, lat, rd, ngr, ga, gwe, gwd, sr);
    ref_mem[8'h10] = 32'hCAFE0001;
    checks++;
    if (lat !== 2 || ngr !== 1 || ga !== 8'h10 || gwe !== 1'b1 || gwd !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL write_basic: got lat=%0d grants=%0d addr=%h we=%b wdata=%h required 2 1 10 1 cafe0001",
               lat, ngr, ga, gwe, gwd);
    end
    checks++;
    if (rd !== exp_prdata) begin
      errors++;
      $display("FAIL write_keeps_prdata: got %h required %h", rd, exp_prdata);
    end
    $display("write addr=10 data=cafe0001 lat=%0d", lat);
    idle(1);
  endtask

  task automatic test_read;
    int lat, ngr; logic [31:0] rd, gwd; logic [7:0] ga; logic gwe, sr;
    xfer(32'h10, 1'b0, 32'h0, 3, 0, lat, rd, ngr, ga, gwe, gwd, sr);
    exp_prdata = ref_mem[8'h10];
    checks++;
    if (lat !== 6 || rd !== 32'hCAFE0001 || ngr !== 1 || gwe !== 1'b0) begin
      errors++;
      $display("FAIL read_gnt_delay: got lat=%0d data=%h grants=%0d we=%b required 6 cafe0001 1 0",
               lat, rd, ngr, gwe);
    end
    $display("read addr=10 data=%h lat=%0d", rd, lat);
    idle(1);
  endtask

  task automatic test_random;
    int lat, ngr, g, r, exp_lat; logic [31:0] rd, gwd, a, wd, exp_rd; logic [7:0] ga; logic gwe, sr, wr, inw;
    for (int n = 0; n < 40; n++) begin
      inw = ($urandom_range(0, 3) != 0);
      a   = inw ? 32'($urandom_range(0, 255)) : ($urandom | 32'h100);
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      g   = $urandom_range(0, 3);
      r   = $urandom_range(0, 3);
      xfer(a, wr, wd, g, r, lat, rd, ngr, ga, gwe, gwd, sr);
      if (!inw)    begin exp_lat = 1;         exp_rd = 32'h0; end
      else if (wr) begin exp_lat = 2 + g;     exp_rd = exp_prdata; end
      else         begin exp_lat = 3 + g + r; exp_rd = ref_mem[a[7:0]]; end
      if (inw && wr) ref_mem[a[7:0]] = wd;
      exp_prdata = exp_rd;
      checks++;
      if (lat !== exp_lat || rd !== exp_rd || ngr !== (inw ? 1 : 0)) begin
        errors++;
        $display("FAIL random_%0d: got lat=%0d data=%h grants=%0d required %0d %h %0d",
                 n, lat, rd, ngr, exp_lat, exp_rd, inw ? 1 : 0);
      end
      if (inw) begin
        checks++;
        if (ga !== a[7:0] || gwe !== wr || (wr && gwd !== wd)) begin
          errors++;
          $display("FAIL random_memport_%0d: got addr=%h we=%b wdata=%h required %h %b %h",
                   n, ga, gwe, gwd, a[7:0], wr, wd);
        end
      end
      $display("random %0d addr=%h wr=%b data=%h lat=%0d", n, a, wr, rd, lat);
    end
    idle(1);
  endtask

  task automatic test_back_to_back;
    int lat, ngr, pulses; logic [31:0] rd, gwd, wd; logic [7:0] ga; logic gwe, sr;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      wd = $urandom;
      xfer(32'(i), 1'b1, wd, 0, 0, lat, rd, ngr, ga, gwe, gwd, sr);
      ref_mem[i] = wd;
      if (lat > 0) pulses++;
      checks++;
      if (lat !== 2 || ngr !== 1 || ga !== 8'(i) || gwd !== wd) begin
        errors++;
        $display("FAIL burst_%0d: got lat=%0d grants=%0d addr=%h wdata=%h required 2 1 %h %h",
                 i, lat, ngr, ga, gwd, 8'(i), wd);
      end
      $display("burst write addr=%h data=%h lat=%0d", i, wd, lat);
    end
    checks++;
    if (pulses !== 4) begin
      errors++;
      $display("FAIL burst_pulses: got %0d required 4", pulses);
    end
    idle(1);
  endtask

  task automatic test_window;
    logic req_seen;
    // write 0x105 -> memory word 5
    @(posedge clk); #1;
    paddr = 32'h105; pwrite = 1'b1; pwdata = 32'h5A5A0105;
    b_step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    b_step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (b_mem_req !== 1'b1 || b_mem_addr !== 8'h05 || b_mem_we !== 1'b1 || b_mem_wdata !== 32'h5A5A0105) begin
      errors++;
      $display("FAIL window_offset: got req=%b addr=%h we=%b wdata=%h required 1 05 1 5a5a0105",
               b_mem_req, b_mem_addr, b_mem_we, b_mem_wdata);
    end
    b_step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (b_pready !== 1'b1) begin
      errors++;
      $display("FAIL window_write_ready: got %b required 1", b_pready);
    end
    // read 0x105 back-to-back, load a non-zero prdata
    @(posedge clk); #1;
    paddr = 32'h105; pwrite = 1'b0; psel_b = 1'b1; penable = 1'b0;
    @(negedge clk);
    b_step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    b_step(1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A50105);
    b_step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (b_pready !== 1'b1 || b_prdata !== 32'hA5A50105) begin
      errors++;
      $display("FAIL window_read: got rdy=%b data=%h required 1 a5a50105", b_pready, b_prdata);
    end
    // out-of-window read 0x20 below base
    @(posedge clk); #1;
    paddr = 32'h20; psel_b = 1'b1; penable = 1'b0;
    @(negedge clk);
    req_seen = b_mem_req;
    b_step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    req_seen = req_seen | b_mem_req;
    checks++;
    if (b_pready !== 1'b1 || b_prdata !== 32'h0 || req_seen !== 1'b0 || b_timeout !== 1'b0) begin
      errors++;
      $display("FAIL window_outside: got rdy=%b data=%h req=%b to=%b required 1 0 0 0",
               b_pready, b_prdata, req_seen, b_timeout);
    end
    $display("window read addr=20 data=%h", b_prdata);
    idle(2);
  endtask

  task automatic test_timeout;
    int lat, ngr; logic [31:0] rd, gwd; logic [7:0] ga; logic gwe, sr;
    xfer(32'h10, 1'b0, 32'h0, 1000, 0, lat, rd, ngr, ga, gwe, gwd, sr);
    checks++;
    if (lat !== 9 || rd !== 32'hDEADBEEF || timeout !== 1'b1 || ngr !== 0) begin
      errors++;
      $display("FAIL timeout_gnt: got lat=%0d data=%h to=%b grants=%0d required 9 deadbeef 1 0",
               lat, rd, timeout, ngr);
    end
    $display("timeout gnt lat=%0d data=%h", lat, rd);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; rvalid = 1'b1; rdata = 32'h12345678;
    end
    @(negedge clk);
    checks++;
    if (prdata !== 32'hDEADBEEF || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_late_rvalid: got data=%h to=%b required deadbeef 1", prdata, timeout);
    end
    idle(1);
    xfer(32'h11, 1'b0, 32'h0, 0, 1000, lat, rd, ngr, ga, gwe, gwd, sr);
    checks++;
    if (lat !== 10 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL timeout_rvalid: got lat=%0d data=%h required 10 deadbeef", lat, rd);
    end
    idle(1);
    xfer(32'h10, 1'b0, 32'h0, 1, 1, lat, rd, ngr, ga, gwe, gwd, sr);
    exp_prdata = ref_mem[8'h10];
    checks++;
    if (lat !== 5 || rd !== exp_prdata || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got lat=%0d data=%h to=%b required 5 %h 1", lat, rd, timeout, exp_prdata);
    end
    idle(1);
  endtask

  task automatic test_reset_mid;
    int lat, ngr; logic [31:0] rd, gwd; logic [7:0] ga; logic gwe, sr;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b0; gnt = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: got mem_req=%b required 1", mem_req);
    end
    #2 preset_ni = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || pready !== 1'b0 || timeout !== 1'b0 || prdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got req=%b rdy=%b to=%b data=%h required 0 0 0 0",
               mem_req, pready, timeout, prdata);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    preset_ni = 1'b1;
    idle(2);
    xfer(32'h10, 1'b0, 32'h0, 0, 0, lat, rd, ngr, ga, gwe, gwd, sr);
    checks++;
    if (lat !== 3 || rd !== ref_mem[8'h10] || ngr !== 1) begin
      errors++;
      $display("FAIL reset_mid_recover: got lat=%0d data=%h grants=%0d required 3 %h 1",
               lat, rd, ngr, ref_mem[8'h10]);
    end
    $display("post-reset read addr=10 data=%h lat=%0d", rd, lat);
    idle(1);
  endtask

  initial begin
    logic [31:0] v;
    preset_ni = 1'b0;
    psel = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    exp_prdata = '0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      slave_mem[i] = v;
      ref_mem[i]   = v;
    end
    test_reset();
    test_write();
    test_read();
    test_random();
    test_back_to_back();
    test_window();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_mem_responder.md
APB_MEM_RESPONDER -- requirements
Module: apb_mem_responder

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, APB address width (word index addressing).
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, APB and memory data width.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default 16, memory word-address width.
REQ-004 SHALL have parameter BASE_ADDR, default 0, first APB word address of the window.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waiting on gnt or rvalid (range 1..65535).
REQ-006 SHALL have one clock and an asynchronous, active-low reset: pclk_i  in  1  clock; preset_ni  in  1  async active-low reset.
REQ-007 psel_i  in  1  APB select.
REQ-008 penable_i  in  1  APB enable phase.
REQ-009 paddr_i  in  APB_ADDR_WIDTH  word address.
REQ-010 pwrite_i  in  1  1 = write.
REQ-011 pwdata_i  in  APB_DATA_WIDTH  write data.
REQ-012 prdata_o  out  APB_DATA_WIDTH  read data, registered.
REQ-013 pready_o  out  1  transfer completion.
REQ-014 mem_req_o  out  1  memory request; mem_gnt_i  in  1  grant.
REQ-015 mem_we_o  out  1  write enable; mem_addr_o  out  MEM_ADDR_WIDTH  word address; mem_wdata_o  out  APB_DATA_WIDTH  write data.
REQ-016 mem_rvalid_i  in  1  read response valid; mem_rdata_i  in  APB_DATA_WIDTH  read response data.
REQ-017 timeout_o  out  1  sticky flag, set on any timeout.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, RESP, DONE.
REQ-019 IDLE: on psel_i=1, latch paddr_i, pwrite_i, pwdata_i; in-window -> REQ; out-of-window -> DONE with prdata_o=0, write discarded.
REQ-020 In-window: paddr_i >= BASE_ADDR and (paddr_i - BASE_ADDR) < 2**MEM_ADDR_WIDTH; mem_addr_o = low MEM_ADDR_WIDTH bits of the difference.
REQ-021 REQ: mem_req_o=1 with stable latched we/addr/wdata until mem_gnt_i=1; on gnt: write -> DONE, read -> RESP.
REQ-022 RESP: mem_req_o=0; on mem_rvalid_i=1 register mem_rdata_i into prdata_o -> DONE.
REQ-023 DONE: pready_o = psel_i & penable_i; when pready_o=1 or psel_i=0 -> IDLE.
REQ-024 pready_o SHALL be 0 in every state other than DONE.
REQ-025 Latency (pready high cycle, setup = cycle 0): write with immediate gnt = cycle 2; read with immediate gnt and rvalid next cycle = cycle 3; out-of-window = cycle 1.
REQ-026 16-bit wait counter cleared on entry to REQ and RESP, increments each cycle there; reaching TIMEOUT_CYCLES -> DONE, prdata_o=32'hDEAD_BEEF (truncated/zero-extended to width), timeout_o set.
REQ-027 mem_rvalid_i in IDLE, REQ or DONE SHALL be ignored (stale response after timeout or reset).
REQ-028 prdata_o SHALL hold its value outside DONE; write transfers leave it unchanged.
REQ-029 Back-to-back transfers (psel_i held, new setup in cycle after pready) SHALL be accepted with no extra idle cycle lost beyond REQ-025.

Reset
REQ-030 Async reset SHALL force state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, prdata_o=0, pready_o=0, timeout_o=0, counter=0.
REQ-031 Reset mid-REQ SHALL drop mem_req_o immediately without waiting for pclk_i.

Structure
REQ-032 State enum and DEAD_BEEF constant SHALL live in the shared spi_slave_apb package.
REQ-033 Wait counter SHALL be a sub-module apb_wait_timer (clear, enable, expired).

Verification
REQ-034 Write paddr=0x10 pwdata=0xCAFE0001, gnt immediate -> mem_we_o=1, mem_addr_o=0x10, pready_o cycle 2.
REQ-035 Read 0x10, gnt after 3 cycles, rvalid data 0xCAFE0001 -> prdata_o=0xCAFE0001, pready_o cycle 6.
REQ-036 BASE_ADDR=0x100, read 0x20 -> no mem_req_o, prdata_o=0, pready_o cycle 1.
REQ-037 TIMEOUT_CYCLES=8, gnt never -> pready_o after 8 REQ cycles, prdata_o=0xDEADBEEF, timeout_o=1 held; late rvalid ignored.
REQ-038 Assert preset_ni=0 during REQ -> mem_req_o=0 same cycle; next read proceeds normally.
REQ-039 Burst of 4 writes 0x0..0x3 back-to-back -> 4 mem grants in order, 4 pready pulses.
